// File: rtl/id_pkg.sv
// +-----------------------------------------------------------------------------
// | Module  : id_pkg
// | Purpose : ASCII constants, transmit-state and character-kind types for the
// |           identifier emitter.
// | Rev     : 1.0  initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package id_pkg;

   localparam logic [7:0] ORD_A  = 8'd65;
   localparam logic [7:0] ORD_Z  = 8'd90;
   localparam logic [7:0] ORD_a  = 8'd97;
   localparam logic [7:0] ORD_z  = 8'd122;
   localparam logic [7:0] ORD_0  = 8'd48;
   localparam logic [7:0] ORD_9  = 8'd57;
   localparam logic [7:0] ORD_SP = 8'd32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALPHA = 2'd1,
      DIGIT = 2'd2,
      TERM  = 2'd3
   } id_tx_state_t;

   typedef enum logic [1:0] {
      CK_LETTER = 2'd0,
      CK_DIGIT  = 2'd1,
      CK_SPACE  = 2'd2
   } id_char_kind_t;

   // Inputs never exceed 31, so one conditional subtract reduces any of them mod 26.
   function automatic logic [4:0] wrap26(input logic [4:0] v);
      return (v >= 5'd26) ? (v - 5'd26) : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/id_char_map.sv
// +-----------------------------------------------------------------------------
// | Module  : id_char_map
// | Purpose : Combinational map from {kind, case, letter index / BCD nibble} to
// |           an ASCII byte; holds the 26-wrap and digit-saturate rules.
// | Rev     : 1.0  initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module id_char_map
   import id_pkg::*;
(
   input  id_char_kind_t kind,
   input  logic          upper,
   input  logic [4:0]    val,
   output logic [7:0]    ch
);

   logic [4:0] w_idx;
   logic [7:0] w_base;

   assign w_idx  = wrap26(val);
   assign w_base = upper ? ORD_A : ORD_a;

   always_comb begin
      ch = ORD_SP;
      case (kind)
         CK_LETTER: ch = w_base + {3'b000, w_idx};
         CK_DIGIT:  ch = (val[3:0] > 4'd9) ? ORD_9 : (ORD_0 + {4'b0000, val[3:0]});
         default:   ch = ORD_SP;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/id_emitter.sv
// +-----------------------------------------------------------------------------
// | Module  : id_emitter
// | Purpose : Emits a legal identifier (letters then BCD digits, MSD first) one
// |           ASCII char per valid/ready handshake. Define ID_TERM_EN to append
// |           a trailing space terminator.
// | Rev     : 1.0  initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module id_emitter
   import id_pkg::*;
#(
   parameter int MAX_DIG = 8
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [3:0]           alpha_len,
   input  logic [4:0]           alpha_seed,
   input  logic                 upper,
   input  logic [3:0]           dig_len,
   input  logic [4*MAX_DIG-1:0] dig_bcd,
   output logic [7:0]           char_out,
   output logic                 char_valid,
   input  logic                 char_ready,
   output logic                 busy,
   output logic                 done
);

   id_tx_state_t         state_q, state_d;
   logic [7:0]           char_q, char_d;
   logic                 valid_q, valid_d;
   logic                 done_q, done_d;
   logic                 upper_q, upper_d;
   logic [3:0]           alen_q, alen_d;
   logic [3:0]           dlen_q, dlen_d;
   logic [4*MAX_DIG-1:0] bcd_q, bcd_d;
   logic [4:0]           idx_q, idx_d;
   logic [3:0]           lcnt_q, lcnt_d;
   logic [3:0]           dcnt_q, dcnt_d;

   logic                 w_xfer;
   logic                 w_last_letter;
   logic                 w_last_digit;
   logic                 w_end;
   logic [3:0]           w_dsel;
   logic [3:0]           w_nib;
   id_char_kind_t        w_map_kind;
   logic                 w_map_upper;
   logic [4:0]           w_map_val;
   logic [7:0]           w_map_ch;

   assign w_xfer        = valid_q & char_ready;
   assign w_last_letter = (lcnt_q == (alen_q - 4'd1));
   assign w_last_digit  = (dcnt_q == 4'd0);

   // The map always looks one char ahead: the byte to load on the next transfer.
   always_comb begin
      w_dsel = (state_q == ALPHA) ? (dlen_q - 4'd1) : (dcnt_q - 4'd1);
      w_nib  = 4'd0;
      for (int i = 0; i < MAX_DIG; i++) begin
         if (w_dsel == 4'(i)) begin
            w_nib = bcd_q[4*i +: 4];
         end
      end
   end

   always_comb begin
      w_map_kind  = CK_SPACE;
      w_map_upper = upper_q;
      w_map_val   = 5'd0;
      case (state_q)
         IDLE: begin
            w_map_kind  = CK_LETTER;
            w_map_upper = upper;
            w_map_val   = alpha_seed;
         end
         ALPHA: begin
            if (!w_last_letter) begin
               w_map_kind = CK_LETTER;
               w_map_val  = idx_q + 5'd1;
            end else if (dlen_q != 4'd0) begin
               w_map_kind = CK_DIGIT;
               w_map_val  = {1'b0, w_nib};
            end
         end
         DIGIT: begin
            if (!w_last_digit) begin
               w_map_kind = CK_DIGIT;
               w_map_val  = {1'b0, w_nib};
            end
         end
         default: w_map_kind = CK_SPACE;
      endcase
   end

   id_char_map u_map (
      .kind  (w_map_kind),
      .upper (w_map_upper),
      .val   (w_map_val),
      .ch    (w_map_ch)
   );

   always_comb begin
      state_d = state_q;
      char_d  = char_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      upper_d = upper_q;
      alen_d  = alen_q;
      dlen_d  = dlen_q;
      bcd_d   = bcd_q;
      idx_d   = idx_q;
      lcnt_d  = lcnt_q;
      dcnt_d  = dcnt_q;
      w_end   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ALPHA;
               valid_d = 1'b1;
               char_d  = w_map_ch;
               upper_d = upper;
               alen_d  = (alpha_len == 4'd0) ? 4'd1 : alpha_len;
               dlen_d  = (dig_len > 4'(MAX_DIG)) ? 4'(MAX_DIG) : dig_len;
               bcd_d   = dig_bcd;
               idx_d   = wrap26(alpha_seed);
               lcnt_d  = 4'd0;
               dcnt_d  = 4'd0;
            end
         end
         ALPHA: begin
            if (w_xfer) begin
               if (!w_last_letter) begin
                  lcnt_d = lcnt_q + 4'd1;
                  idx_d  = (idx_q == 5'd25) ? 5'd0 : (idx_q + 5'd1);
                  char_d = w_map_ch;
               end else if (dlen_q != 4'd0) begin
                  state_d = DIGIT;
                  dcnt_d  = dlen_q - 4'd1;
                  char_d  = w_map_ch;
               end else begin
                  w_end = 1'b1;
               end
            end
         end
         DIGIT: begin
            if (w_xfer) begin
               if (!w_last_digit) begin
                  dcnt_d = dcnt_q - 4'd1;
                  char_d = w_map_ch;
               end else begin
                  w_end = 1'b1;
               end
            end
         end
         default: begin
            if (w_xfer) begin
               state_d = IDLE;
               valid_d = 1'b0;
               char_d  = 8'h00;
               done_d  = 1'b1;
            end
         end
      endcase

      if (w_end) begin
`ifdef ID_TERM_EN
         state_d = TERM;
         char_d  = ORD_SP;
`else
         state_d = IDLE;
         valid_d = 1'b0;
         char_d  = 8'h00;
         done_d  = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         char_q  <= 8'h00;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         upper_q <= 1'b0;
         alen_q  <= 4'd0;
         dlen_q  <= 4'd0;
         bcd_q   <= '0;
         idx_q   <= 5'd0;
         lcnt_q  <= 4'd0;
         dcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         char_q  <= char_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         upper_q <= upper_d;
         alen_q  <= alen_d;
         dlen_q  <= dlen_d;
         bcd_q   <= bcd_d;
         idx_q   <= idx_d;
         lcnt_q  <= lcnt_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign char_out   = char_q;
   assign char_valid = valid_q;
   assign done       = done_q;
   assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire
